// File: rtl/apb_ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the APB-to-AHB master path.
// No ports: package imported by apb2ahb_mst.
package apb_ahb_pkg;

  // AHB-Lite htrans encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB-Lite hresp encodings
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Fixed transfer attributes: single 32-bit word
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Anything other than OKAY counts as an error response.
  function automatic logic resp_is_okay(input logic [1:0] resp);
    return (resp == HRESP_OKAY);
  endfunction

endpackage

// File: rtl/apb2ahb_mst.sv
// APB3 responder that turns each APB access into one AHB-Lite single word
// transfer, one outstanding transfer at a time.
// Ports:
//   pclk, prst            clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata  APB request
//   prdata/pready/pslverr             APB response (registered)
//   haddr/htrans/hwrite/hwdata        AHB master request (registered)
//   hsize/hburst/hprot/hmastlock      fixed AHB attributes
//   hrdata/hready/hresp               AHB slave response
module apb2ahb_mst
  import apb_ahb_pkg::*;
#(
  parameter int          ADDR_W    = 40,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);

  state_e            state_q,   state_d;
  logic [ADDR_W-1:0] haddr_q,   haddr_d;
  logic [1:0]        htrans_q,  htrans_d;
  logic              hwrite_q,  hwrite_d;
  logic [31:0]       hwdata_q,  hwdata_d;
  logic [31:0]       wdata_q,   wdata_d;   // pwdata held until the data phase
  logic [31:0]       prdata_q,  prdata_d;
  logic              pready_q,  pready_d;
  logic              pslverr_q, pslverr_d;

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    htrans_d  = htrans_q;
    hwrite_d  = hwrite_q;
    hwdata_d  = hwdata_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;   // pready/pslverr are single-cycle pulses
    pslverr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          wdata_d = pwdata;
          if (paddr[1:0] != 2'b00) begin
            // Misaligned: answer with an error, never touch the AHB bus.
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = 32'h0000_0000;
          end else begin
            // haddr/hwrite double as the address/direction holding registers.
            state_d  = ST_ADDR;
            haddr_d  = paddr;
            hwrite_d = pwrite;
            htrans_d = HTRANS_NONSEQ;
          end
        end else if (psel && penable) begin
          // Access phase without a setup we saw: reject it.
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = 32'h0000_0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end else begin
            hwdata_d = hwdata_q;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        // hready=0 (including the first ERROR cycle) just keeps waiting.
        if (hready) begin
          state_d  = ST_RESP;
          pready_d = 1'b1;
          if (resp_is_okay(hresp)) begin
            pslverr_d = 1'b0;
            prdata_d  = hwrite_q ? 32'h0000_0000 : hrdata;
          end else begin
            pslverr_d = 1'b1;
            prdata_d  = 32'h0000_0000;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase
  end

  // State and output registers, cleared synchronously by prst.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q   <= ST_IDLE;
      haddr_q   <= {ADDR_W{1'b0}};
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hwdata_q  <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      prdata_q  <= 32'h0000_0000;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;
  assign hsize     = HSIZE_WORD;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;

endmodule

// File: tb/tb_apb2ahb_mst.sv
// Self-checking bench for apb2ahb_mst: directed table, randomized transfers
// against a result model, and hand-written reset / back-to-back sequences.
module tb_apb2ahb_mst;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [39:0] paddr = 40'h0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [39:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic [31:0] hrdata = 32'h0;
  logic        hready = 1'b1;
  logic [1:0]  hresp = 2'b00;

  apb2ahb_mst #(.ADDR_W(40), .HPROT_VAL(4'b0011)) dut (
    .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 pclk = ~pclk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h req=%h", name, act, exp);
  endtask

  typedef struct {
    logic [39:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          aw;        // slave wait cycles in address phase
    int          dw;        // slave wait cycles in data phase
    logic        err;       // slave gives two-cycle ERROR
    logic [31:0] rdata;     // slave read data
    logic        b2b;       // next access follows with no idle cycle
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;   // cycles from setup to pready
    int          exp_n;     // AHB transfers expected
  } vec_t;

  // Slave configuration and bookkeeping shared with the slave process.
  int          cfg_aw = 0, cfg_dw = 0;
  logic        cfg_err = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [39:0] cur_addr = 40'h0;
  logic        cur_write = 1'b0;
  logic [31:0] cur_wdata = 32'h0;
  logic        data_ph = 1'b0;
  int          aw_cnt = 0, dw_cnt = 0;
  logic [40:0] ahb_log[$];

  // AHB slave: decides hready/hresp/hrdata for the current cycle mid-cycle.
  always @(negedge pclk) begin
    if (prst) begin
      hready = 1'b1; hresp = 2'b00; hrdata = 32'h0;
      data_ph = 1'b0; aw_cnt = 0; dw_cnt = 0;
      ahb_log.delete();
    end else if (data_ph) begin
      chk("htrans_in_data", {62'd0, htrans}, 64'd0);
      if (cur_write) chk("hwdata_hold", {32'd0, hwdata}, {32'd0, cur_wdata});
      if (dw_cnt < cfg_dw) begin
        hready = 1'b0;
        hresp  = (cfg_err && dw_cnt == cfg_dw - 1) ? 2'b01 : 2'b00;
        hrdata = 32'hBAD0_BAD0;
        dw_cnt++;
      end else begin
        hready = 1'b1;
        hresp  = cfg_err ? 2'b01 : 2'b00;
        hrdata = cfg_rdata;
        data_ph = 1'b0;
      end
    end else if (htrans == 2'b10) begin
      chk("haddr_addr_phase", {24'd0, haddr}, {24'd0, cur_addr});
      chk("hwrite_addr_phase", {63'd0, hwrite}, {63'd0, cur_write});
      hresp = 2'b00;
      if (aw_cnt < cfg_aw) begin
        hready = 1'b0;
        aw_cnt++;
      end else begin
        hready = 1'b1;
        aw_cnt = 0; dw_cnt = 0; data_ph = 1'b1;
        ahb_log.push_back({hwrite, haddr});
      end
    end else begin
      hready = 1'b1; hresp = 2'b00; hrdata = 32'hBAD0_BAD0;
    end
  end

  // Reference model: outcome of one APB access from the access rules alone.
  function automatic vec_t model(input logic [39:0] addr, input logic wr,
                                 input logic [31:0] wdata, input int aw, input int dw,
                                 input logic err, input logic [31:0] rdata, input logic b2b);
    vec_t v;
    logic misal;
    misal = (addr[1:0] != 2'b00);
    v.addr = addr; v.wr = wr; v.wdata = wdata; v.aw = aw; v.dw = dw;
    v.err = err; v.rdata = rdata; v.b2b = b2b;
    v.exp_err   = misal | err;
    v.exp_rdata = (misal || err || wr) ? 32'h0 : rdata;
    v.exp_lat   = misal ? 1 : 3 + aw + dw;
    v.exp_n     = misal ? 0 : 1;
    return v;
  endfunction

  task automatic apb_setup(input logic [39:0] addr, input logic wr, input logic [31:0] wdata);
    cur_addr = addr; cur_write = wr; cur_wdata = wdata;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int cyc;
    logic [40:0] ent;
    cfg_aw = v.aw; cfg_dw = v.dw; cfg_err = v.err; cfg_rdata = v.rdata;
    @(negedge pclk);
    chk({tag, "_pready_before"}, {63'd0, pready}, 64'd0);
    chk({tag, "_pslverr_before"}, {63'd0, pslverr}, 64'd0);
    apb_setup(v.addr, v.wr, v.wdata);
    @(negedge pclk);
    chk({tag, "_htrans_after_setup"}, {62'd0, htrans}, (v.exp_n == 1) ? 64'd2 : 64'd0);
    if (v.exp_n == 1) chk({tag, "_haddr_after_setup"}, {24'd0, haddr}, {24'd0, v.addr});
    penable = 1'b1;
    cyc = 1;
    while (pready !== 1'b1 && cyc < 100) begin
      @(negedge pclk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(v.exp_lat));
    chk({tag, "_prdata"}, {32'd0, prdata}, {32'd0, v.exp_rdata});
    chk({tag, "_pslverr"}, {63'd0, pslverr}, {63'd0, v.exp_err});
    chk({tag, "_ahb_count"}, 64'(ahb_log.size()), 64'(v.exp_n));
    if (ahb_log.size() > 0) begin
      ent = ahb_log.pop_front();
      chk({tag, "_ahb_xfer"}, {23'd0, ent}, {23'd0, v.wr, v.addr});
    end
    if (!v.b2b) begin
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [63:0] r;
    logic [39:0] a;
    logic [1:0]  lo;
    logic        e;
    int          dw;

    vecs[0] = '{40'h10_0000_0004, 1'b0, 32'h0,         0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1};
    vecs[1] = '{40'h00_2000_0010, 1'b1, 32'h1234_5678, 2, 3, 1'b0, 32'h1111_1111, 1'b0, 32'h0,        1'b0, 8, 1};
    vecs[2] = '{40'h00_0000_0100, 1'b0, 32'h0,         0, 1, 1'b1, 32'h0000_0055, 1'b0, 32'h0,        1'b1, 4, 1};
    vecs[3] = '{40'h00_0000_0102, 1'b0, 32'h0,         0, 0, 1'b0, 32'h7777_7777, 1'b0, 32'h0,        1'b1, 1, 0};
    vecs[4] = '{40'hFF_FFFF_FFFC, 1'b0, 32'h0,         1, 0, 1'b0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0, 4, 1};
    vecs[5] = '{40'h00_0000_0008, 1'b1, 32'hA5A5_5A5A, 0, 0, 1'b0, 32'h2222_2222, 1'b0, 32'h0,        1'b0, 3, 1};
    vecs[6] = '{40'h00_0000_0200, 1'b1, 32'h0BAD_CAFE, 0, 2, 1'b1, 32'h3333_3333, 1'b0, 32'h0,        1'b1, 5, 1};
    vecs[7] = '{40'h00_0000_0301, 1'b1, 32'h5555_AAAA, 0, 0, 1'b0, 32'h4444_4444, 1'b0, 32'h0,        1'b1, 1, 0};

    // Reset state
    repeat (3) @(negedge pclk);
    chk("rst_pready",  {63'd0, pready},  64'd0);
    chk("rst_pslverr", {63'd0, pslverr}, 64'd0);
    chk("rst_prdata",  {32'd0, prdata},  64'd0);
    chk("rst_htrans",  {62'd0, htrans},  64'd0);
    chk("rst_haddr",   {24'd0, haddr},   64'd0);
    chk("rst_hwrite",  {63'd0, hwrite},  64'd0);
    chk("rst_hwdata",  {32'd0, hwdata},  64'd0);
    chk("fixed_attrs", {52'd0, hsize, hburst, hprot, hmastlock, 1'b0}, {52'd0, 3'b010, 3'b000, 4'b0011, 1'b0, 1'b0});
    prst = 1'b0;

    // Directed table; entry 4 runs straight into entry 5 (back-to-back).
    for (int i = 0; i < 8; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Reset while in DATA, then a fresh read.
    cfg_aw = 0; cfg_dw = 5; cfg_err = 1'b0; cfg_rdata = 32'h9999_9999;
    @(negedge pclk);
    apb_setup(40'h00_0000_0040, 1'b0, 32'h0);
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    chk("rstmid_in_data", {63'd0, data_ph}, 64'd1);
    prst = 1'b1;
    @(negedge pclk);
    chk("rstmid_htrans", {62'd0, htrans}, 64'd0);
    chk("rstmid_pready", {63'd0, pready}, 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    prst = 1'b0;
    run_xfer(model(40'h00_0000_0044, 1'b0, 32'h0, 0, 0, 1'b0, 32'h600D_600D, 1'b0), "after_rst");

    // Randomized transfers against the model.
    for (int i = 0; i < 40; i++) begin
      r  = {$urandom(), $urandom()};
      a  = r[39:0];
      lo = 2'($urandom_range(1, 3));
      a[1:0] = ($urandom_range(0, 5) == 0) ? lo : 2'b00;
      e  = ($urandom_range(0, 4) == 0);
      dw = $urandom_range(0, 3);
      if (e && dw == 0) dw = 1;
      v = model(a, 1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 3), dw, e,
                $urandom(), 1'($urandom_range(0, 1)));
      run_xfer(v, $sformatf("rnd%0d", i));
    end

    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb2ahb_mst.md
Name: apb2ahb_mst

Overview:
- APB3 responder that converts each APB access into one AHB-Lite single transfer as bus master.
- This is the reverse direction of the existing AHB-to-APB path. It lets APB-side agents (PMU save/restore sequencer, debug helpers) reach AHB-only slaves such as the SRAM and the AHB system bus.
- It sits on the per_clk domain, as one psel slot of the APB bridge on the APB side and one AHB arbiter master port on the AHB side.
- Transfers are 32-bit word accesses only, with no bursts or pipelining. There is one outstanding transfer at a time.

Parameters:
- ADDR_W, 40, address width on both APB paddr and AHB haddr.
- HPROT_VAL, 4'b0011, constant hprot driven with every transfer (data access, privileged).

Ports:
- pclk  in  1  clock (per_clk at the instance).
- prst  in  1  reset, synchronous, active-high.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB direction.
- paddr  in  ADDR_W  APB address.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- haddr  out  ADDR_W  AHB address.
- htrans  out  2  AHB transfer type (IDLE=2'b00, NONSEQ=2'b10).
- hwrite  out  1  AHB direction.
- hsize  out  3  fixed 3'b010.
- hburst  out  3  fixed 3'b000 (SINGLE).
- hprot  out  4  HPROT_VAL.
- hmastlock  out  1  fixed 0.
- hwdata  out  32  AHB write data.
- hrdata  in  32  AHB read data.
- hready  in  1  AHB ready.
- hresp  in  2  AHB response (OKAY=2'b00, ERROR=2'b01; others treated as ERROR).

Behaviour:
- One clock, pclk. Reset is synchronous and active-high (prst).
- All outputs are registered.
- Reset values:
  - prdata=0, pready=0, pslverr=0.
  - htrans=IDLE, haddr=0, hwrite=0, hwdata=0.
  - FSM in IDLE.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On psel & !penable (setup), capture paddr, pwrite and pwdata into holding registers.
  - If paddr[1:0]!=0, go to RESP with err=1 and issue no AHB transfer.
  - Otherwise go to ADDR: htrans=NONSEQ, haddr and hwrite from the holding registers, valid on the next cycle.
  - If psel & penable arrives with no captured setup (protocol violation), go to RESP with err=1.
- ADDR: htrans=NONSEQ is held.
  - hready=0: stay in ADDR, with haddr, htrans and hwrite stable.
  - hready=1: the address is accepted. Next cycle htrans=IDLE, hwdata=held pwdata (writes), and the FSM goes to DATA.
- DATA: wait for hready.
  - hready=1 with hresp OKAY: capture hrdata into prdata (reads only; writes leave prdata=0), err=0, go to RESP.
  - hready=1 with hresp!=OKAY: err=1, prdata=0, go to RESP.
  - hready=0 with hresp=ERROR: first cycle of the two-cycle error; keep waiting.
- RESP:
  - pready=1 and pslverr=err for exactly one cycle.
  - The FSM returns to IDLE the next cycle; pready and pslverr return to 0.
- Latency with a zero-wait-state slave:
  - Setup at cycle T0, ADDR at T1, DATA at T2, pready=1 at T3.
  - This is 2 APB wait states; each AHB wait cycle adds 1.
- hwdata is held stable from DATA entry until RESP.
- APB inputs are ignored outside IDLE. The APB master must hold them per APB3, and they are not re-sampled.
- Back-to-back accesses: a new setup may arrive in the cycle after RESP. It is accepted in IDLE with no bubble beyond IDLE itself.
- Reset mid-transfer:
  - The next edge forces htrans=IDLE, pready=0 and the FSM to IDLE.
  - The AHB system is reset together with this block (same reset net), so no abandoned-transfer recovery is needed.
- A psel drop mid-transfer (illegal) does not abort the AHB transfer; the transfer completes and pready is still pulsed.

Decomposition:
- Shared package apb_ahb_pkg:
  - htrans encodings: IDLE, BUSY, NONSEQ, SEQ.
  - hresp encodings: OKAY, ERROR.
  - HSIZE_WORD, HBURST_SINGLE.
  - FSM state enum.
- No sub-module: a single FSM plus holding registers.

Test Plan:
- Read, zero-wait slave: hrdata=32'hDEADBEEF, paddr=40'h10_0000_0004 → haddr=paddr with htrans=NONSEQ one cycle after setup; pready=1 with prdata=32'hDEADBEEF, pslverr=0 exactly 3 cycles after setup.
- Write with slave wait states: 2 hready=0 cycles in ADDR and 3 in DATA, pwdata=32'h1234_5678 → haddr and htrans stable while stalled; hwdata=32'h1234_5678 through DATA; pready at setup+8.
- AHB error: two-cycle ERROR response (hready=0/hresp=01, then hready=1/hresp=01) → pslverr=1, prdata=0, single pready pulse.
- Misaligned: paddr[1:0]=2'b10 → htrans stays IDLE for the whole access; pready=1 with pslverr=1 on the cycle after setup.
- Back-to-back: read then write with no idle APB cycles → both complete, AHB sees exactly 2 NONSEQ transfers in order, prdata correct for the read.
- Reset: assert prst while in DATA → next cycle htrans=IDLE and pready=0; after release, a fresh read completes normally.
